// File: rtl/instruction_decode_stage.sv
// RV32I decode stage: register file with writeback bypass, immediate generation,
// load-use hazard detection and the ID/EX pipeline register.
module instruction_decode_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_instr,
  input  logic        id_false_nop,
  input  logic        MA_stall,
  input  logic        br_miss,
  input  logic        wb_load,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        bubble,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_instr,
  output logic [31:0] ex_rs1_val,
  output logic [31:0] ex_rs2_val,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rs1,
  output logic [4:0]  ex_rs2,
  output logic [4:0]  ex_rd,
  output logic        ex_valid
);

  localparam int DATA_W = 32;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  function automatic logic signed [DATA_W-1:0] gen_imm(input logic [31:0] ins);
    logic signed [DATA_W-1:0] imm;
    case (ins[6:0])
      OP_LOAD, OP_OPIMM, OP_JALR:
        imm = {{20{ins[31]}}, ins[31:20]};
      OP_STORE:
        imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      OP_BRANCH:
        imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        imm = {ins[31:12], 12'h000};
      OP_JAL:
        imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default:
        imm = '0;
    endcase
    return imm;
  endfunction

  function automatic logic uses_rs1(input logic [6:0] op);
    return (op == OP_JALR) || (op == OP_BRANCH) || (op == OP_LOAD) ||
           (op == OP_STORE) || (op == OP_OPIMM) || (op == OP_OP);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == OP_BRANCH) || (op == OP_STORE) || (op == OP_OP);
  endfunction

  logic [DATA_W-1:0] regs [32];

  logic [4:0]  rs1_p0, rs2_p0, rd_p0;
  logic [6:0]  opc_p0;
  logic [DATA_W-1:0] rs1_val_p0, rs2_val_p0;
  logic signed [DATA_W-1:0] imm_p0;

  logic [31:0] pc_p1, instr_p1, rs1_val_p1, rs2_val_p1;
  logic signed [DATA_W-1:0] imm_p1;
  logic [4:0]  rs1_p1, rs2_p1, rd_p1;
  logic        vld_p1;

  assign rs1_p0 = id_instr[19:15];
  assign rs2_p0 = id_instr[24:20];
  assign rd_p0  = id_instr[11:7];
  assign opc_p0 = id_instr[6:0];
  assign imm_p0 = gen_imm(id_instr);

  // Register file; x0 is never written so it stays zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wb_load && (wb_rd != 5'd0)) begin
      regs[wb_rd] <= wb_data;
    end
  end

  always_comb begin
    rs1_val_p0 = regs[rs1_p0];
    rs2_val_p0 = regs[rs2_p0];
    if (wb_load && (wb_rd != 5'd0) && (wb_rd == rs1_p0)) rs1_val_p0 = wb_data;
    if (wb_load && (wb_rd != 5'd0) && (wb_rd == rs2_p0)) rs2_val_p0 = wb_data;
    if (rs1_p0 == 5'd0) rs1_val_p0 = '0;
    if (rs2_p0 == 5'd0) rs2_val_p0 = '0;
  end

  always_comb begin
    bubble = vld_p1 && (instr_p1[6:0] == OP_LOAD) && (rd_p1 != 5'd0) &&
             !id_false_nop && !br_miss &&
             ((uses_rs1(opc_p0) && (rs1_p0 == rd_p1)) ||
              (uses_rs2(opc_p0) && (rs2_p0 == rd_p1)));
  end

  // ID/EX register: rst > br_miss > MA_stall > bubble > load
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_p1      <= '0;
      instr_p1   <= NOP_INSTR;
      vld_p1     <= 1'b0;
      imm_p1     <= '0;
      rs1_p1     <= '0;
      rs2_p1     <= '0;
      rd_p1      <= '0;
      rs1_val_p1 <= '0;
      rs2_val_p1 <= '0;
    end else if (br_miss || (bubble && !MA_stall)) begin
      pc_p1      <= id_pc;
      instr_p1   <= NOP_INSTR;
      vld_p1     <= 1'b0;
      imm_p1     <= '0;
      rs1_p1     <= '0;
      rs2_p1     <= '0;
      rd_p1      <= '0;
      rs1_val_p1 <= '0;
      rs2_val_p1 <= '0;
    end else if (!MA_stall) begin
      pc_p1      <= id_pc;
      instr_p1   <= id_instr;
      vld_p1     <= !id_false_nop;
      imm_p1     <= imm_p0;
      rs1_p1     <= rs1_p0;
      rs2_p1     <= rs2_p0;
      rd_p1      <= rd_p0;
      rs1_val_p1 <= rs1_val_p0;
      rs2_val_p1 <= rs2_val_p0;
    end
  end

  assign ex_pc      = pc_p1;
  assign ex_instr   = instr_p1;
  assign ex_valid   = vld_p1;
  assign ex_imm     = imm_p1;
  assign ex_rs1     = rs1_p1;
  assign ex_rs2     = rs2_p1;
  assign ex_rd      = rd_p1;
  assign ex_rs1_val = rs1_val_p1;
  assign ex_rs2_val = rs2_val_p1;

endmodule

// File: doc/instruction_decode_stage.md
INSTRUCTION_DECODE_STAGE -- requirements
Module: instruction_decode_stage

Interface
REQ-001 SHALL have parameter NOP_INSTR, default 32'h00000013, meaning the encoding written into the ID/EX register on flush or bubble.
REQ-002 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port id_pc  input  32  PC of the instruction held in IF/ID.
REQ-005 SHALL have port id_instr  input  32  instruction word held in IF/ID.
REQ-006 SHALL have port id_false_nop  input  1  IF/ID holds a fetch-inserted NOP.
REQ-007 SHALL have port MA_stall  input  1  memory stage stalled; ID/EX holds.
REQ-008 SHALL have port br_miss  input  1  branch mispredict; flush ID/EX.
REQ-009 SHALL have port wb_load  input  1  register-file write enable from writeback.
REQ-010 SHALL have port wb_rd  input  5  writeback destination index.
REQ-011 SHALL have port wb_data  input  32  writeback data.
REQ-012 SHALL have port bubble  output  1  load-use hazard; IF and IF/ID hold this cycle.
REQ-013 SHALL have ports ex_pc, ex_instr, ex_rs1_val, ex_rs2_val, ex_imm  output  32 each  registered ID/EX fields.
REQ-014 SHALL have ports ex_rs1, ex_rs2, ex_rd  output  5 each  registered register indices.
REQ-015 SHALL have port ex_valid  output  1  ID/EX holds a real (non-inserted) instruction.

Function
REQ-016 SHALL contain a 32x32 register file; x0 reads as 0; writes to x0 ignored.
REQ-017 SHALL write wb_data to wb_rd on a clock edge when wb_load=1 and wb_rd!=0.
REQ-018 SHALL bypass: if wb_load=1, wb_rd!=0 and wb_rd equals rs1/rs2 in the same cycle, the read value SHALL be wb_data.
REQ-019 SHALL decode rs1=instr[19:15], rs2=instr[24:20], rd=instr[11:7], opcode=instr[6:0].
REQ-020 SHALL generate imm sign-extended per RV32I: I-type (LOAD, OP-IMM, JALR), S (STORE), B (BRANCH, bit0=0), U (LUI, AUIPC, low 12 bits 0), J (JAL, bit0=0); imm=0 for other opcodes.
REQ-021 SHALL treat rs1 as used for JALR, BRANCH, LOAD, STORE, OP-IMM, OP; rs2 as used for BRANCH, STORE, OP.
REQ-022 SHALL drive bubble=1 combinationally iff ex_valid=1, ex_instr opcode is LOAD, ex_rd!=0, id_false_nop=0, br_miss=0, and a used source index equals ex_rd.
REQ-023 SHALL update ID/EX with priority: rst > br_miss > MA_stall > bubble > normal load.
REQ-024 On br_miss (and on bubble when not MA_stall): ex_instr=NOP_INSTR, ex_valid=0, ex_imm=0, ex_rs1/ex_rs2/ex_rd=0, ex_rs1_val/ex_rs2_val=0, ex_pc=id_pc.
REQ-025 On MA_stall (no br_miss): all ID/EX outputs SHALL hold.
REQ-026 Normal load: ID/EX captures id_pc, id_instr, decoded indices, read values, imm; ex_valid=!id_false_nop.
REQ-027 br_miss concurrent with MA_stall SHALL flush (flush wins).
REQ-028 Latency: decode to ID/EX outputs is exactly one cycle; a bubble delays the dependent instruction by exactly one cycle.

Reset
REQ-029 On rst: all 32 registers=0; ex_pc=0, ex_instr=NOP_INSTR, ex_valid=0, all other ex_* =0; bubble evaluates 0 the following cycle.
REQ-030 rst asserted mid-stall or mid-bubble SHALL override all other inputs that cycle.

Verification
REQ-031 wb writes x5=0xDEADBEEF; next cycle id_instr=ADD x6,x5,x0 -> ex_rs1_val=0xDEADBEEF, ex_rd=6, ex_valid=1.
REQ-032 Same-cycle wb_rd=7, wb_data=0x1234 with id_instr reading x7 -> ex_rs1_val=0x1234 (bypass); wb_rd=0 write -> x0 still reads 0.
REQ-033 LW x8 into ID/EX, then ADD x9,x8,x1 in IF/ID -> bubble=1 one cycle, ex_instr=0x00000013, ex_valid=0; next cycle ADD captured, bubble=0.
REQ-034 LW x8 then ADDI x9,x0,1 (rs1=x0) or LUI x8 -> bubble=0.
REQ-035 br_miss=1 with MA_stall=1 -> next cycle ex_instr=0x00000013, ex_valid=0; MA_stall alone for 3 cycles -> ex_* unchanged.
REQ-036 BEQ with offset -8 (instr 0xFE000CE3) -> ex_imm=0xFFFFFFF8; JAL offset +2048 -> ex_imm=0x00000800.
